// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: bus word and RAM handshake types shared by the caches,
// plus the coherence controller state and arbitration class encodings.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [2:0] {IDLE, WB, SNOOP, SRESP, C2C, RAMLD, IFETCH} cc_state_t;
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_WB   = 2'd1;
    localparam logic [1:0] CLS_CC   = 2'd2;
    localparam logic [1:0] CLS_IF   = 2'd3;
endpackage

// File: rtl/cc_rr_arbiter.sv
// cc_rr_arbiter: two-CPU arbiter with writeback > coherent > ifetch classes,
// round-robin between CPUs inside the winning class.
module cc_rr_arbiter
    import cpu_types_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] wb_i,
    input  logic [1:0] cc_i,
    input  logic [1:0] fetch_i,
    input  logic       done_i,
    input  logic       done_cpu_i,
    output logic       gnt_o,
    output logic [1:0] cls_o
);
    logic       rr_last_q, rr_last_d;
    logic [1:0] req;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rr_last_q <= 1'b1;
        else         rr_last_q <= rr_last_d;

    always_comb begin
        rr_last_d = done_i ? done_cpu_i : rr_last_q;
        cls_o     = |wb_i ? CLS_WB : |cc_i ? CLS_CC : |fetch_i ? CLS_IF : CLS_NONE;
        req       = |wb_i ? wb_i : |cc_i ? cc_i : fetch_i;
        // a lone requester is its own index; a tie goes to the CPU not served last
        gnt_o     = &req ? ~rr_last_q : req[1];
    end
endmodule

// File: rtl/coherence_control.sv
// coherence_control: arbitrates icache/dcache traffic of two CPUs onto one RAM
// port and runs MSI snooping with invalidation and cache-to-cache transfers.
module coherence_control
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  word_t [CPUS-1:0]      iaddr,
    input  word_t [CPUS-1:0]      daddr,
    input  word_t [CPUS-1:0]      dstore,
    input  logic [CPUS-1:0]       ccwrite,
    input  logic [CPUS-1:0]       cctrans,
    input  word_t                 ramload,
    input  ramstate_t             ramstate,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output word_t [CPUS-1:0]      iload,
    output word_t [CPUS-1:0]      dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output word_t [CPUS-1:0]      ccsnoopaddr,
    output word_t                 ramstore,
    output word_t                 ramaddr,
    output logic                  ramWEN,
    output logic                  ramREN
);
    cc_state_t  state_q, state_d;
    logic       gnt_q, gnt_d, chk_q, chk_d;
    logic       arb_gnt, done, g, o, acc;
    logic [1:0] cls;

    assign g   = gnt_q;
    assign o   = ~gnt_q;
    assign acc = (ramstate == ACCESS);

    cc_rr_arbiter u_arb (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .wb_i       (dWEN & ~cctrans),
        .cc_i       (cctrans),
        .fetch_i    (iREN),
        .done_i     (done),
        .done_cpu_i (g),
        .gnt_o      (arb_gnt),
        .cls_o      (cls)
    );

    // chk_q marks the cycle after a completed word, where the requester
    // decides whether the block continues with a second word
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            chk_q   <= chk_d;
        end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        chk_d       = 1'b0;
        done        = 1'b0;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramstore    = '0;
        ramaddr     = '0;
        ramWEN      = 1'b0;
        ramREN      = 1'b0;
        case (state_q)
            IDLE: if (cls != CLS_NONE) begin
                gnt_d   = arb_gnt;
                state_d = cls == CLS_WB ? WB : cls == CLS_CC ? SNOOP : IFETCH;
            end
            WB: if (chk_q && !dWEN[g]) state_d = IDLE;
            else begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                if (acc) begin
                    dwait[g] = 1'b0;
                    done     = 1'b1;
                    chk_d    = 1'b1;
                end
            end
            SNOOP: if (chk_q && !(dREN[g] && cctrans[g])) state_d = IDLE;
            else begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                ccinv[o]       = ccwrite[g];
                if (ccwrite[g] && !dREN[g] && !dWEN[g]) begin
                    dwait[g] = 1'b0;
                    done     = 1'b1;
                    state_d  = IDLE;
                end else state_d = SRESP;
            end
            SRESP: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                state_d        = dWEN[o] ? C2C : RAMLD;
            end
            C2C: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                ramWEN         = 1'b1;
                ramaddr        = daddr[o];
                ramstore       = dstore[o];
                dload[g]       = dstore[o];
                if (acc) begin
                    dwait[o] = 1'b0;
                    dwait[g] = 1'b0;
                    done     = 1'b1;
                    chk_d    = 1'b1;
                    state_d  = SNOOP;
                end
            end
            RAMLD: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                ramREN         = 1'b1;
                ramaddr        = daddr[g];
                if (acc) begin
                    dload[g] = ramload;
                    dwait[g] = 1'b0;
                    done     = 1'b1;
                    chk_d    = 1'b1;
                    state_d  = SNOOP;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g];
                if (acc) begin
                    iload[g] = ramload;
                    iwait[g] = 1'b0;
                    done     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_control.sv
// tb_coherence_control: directed cycle-by-cycle vectors against hand-computed
// bus, cache and snoop responses of coherence_control.
module tb_coherence_control;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic [1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [1:0] iaddr, daddr, dstore;
    word_t ramload;
    ramstate_t ramstate;
    logic [1:0] iwait, dwait, ccwait, ccinv;
    word_t [1:0] iload, dload, ccsnoopaddr;
    word_t ramstore, ramaddr;
    logic ramWEN, ramREN;
    int vecs = 0;
    int errs = 0;

    coherence_control #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
        .cctrans(cctrans), .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramstore(ramstore), .ramaddr(ramaddr), .ramWEN(ramWEN), .ramREN(ramREN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #3;
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_dwait", 64'(dwait), 64'h3);
        chk("rst_ram", 64'({ramREN, ramWEN}), 64'h0);
        chk("rst_ccwait", 64'(ccwait), 64'h0);
        step(); nRST = 1'b1;

        // both icaches miss: CPU0 first, then CPU1
        step(); iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; #1;
        chk("if_idle_ren", 64'(ramREN), 64'h0);
        step(); ramstate = BUSY; #1;
        chk("if0_ren", 64'(ramREN), 64'h1);
        chk("if0_addr", 64'(ramaddr), 64'h100);
        chk("if0_wait_busy", 64'(iwait), 64'h3);
        step(); ramstate = ACCESS; ramload = 32'h1111_0000; #1;
        chk("if0_wait_acc", 64'(iwait), 64'h2);
        chk("if0_iload", 64'(iload), {32'h0, 32'h1111_0000});
        step(); iREN = 2'b10; ramstate = FREE; #1;
        chk("if_gap_wait", 64'(iwait), 64'h3);
        step(); ramstate = ACCESS; ramload = 32'h2222; #1;
        chk("if1_addr", 64'(ramaddr), 64'h200);
        chk("if1_wait", 64'(iwait), 64'h1);
        chk("if1_iload", 64'(iload), {32'h2222, 32'h0});
        step(); iREN = 2'b00; ramstate = FREE;

        // CPU1 writeback beats CPU0 ifetch
        step(); dWEN = 2'b10; daddr[1] = 32'h80; dstore[1] = 32'hDEAD;
        iREN = 2'b01; iaddr[0] = 32'h300; #1;
        chk("wb_idle_wen", 64'(ramWEN), 64'h0);
        step(); ramstate = ACCESS; #1;
        chk("wb_ram", 64'({ramREN, ramWEN}), 64'h1);
        chk("wb_addr", 64'(ramaddr), 64'h80);
        chk("wb_store", 64'(ramstore), 64'hDEAD);
        chk("wb_dwait", 64'(dwait), 64'h1);
        chk("wb_iwait", 64'(iwait), 64'h3);
        step(); dWEN = 2'b00; ramstate = FREE; #1;
        chk("wb_end_ram", 64'({ramREN, ramWEN}), 64'h0);
        chk("wb_end_dwait", 64'(dwait), 64'h3);
        step(); #1;
        chk("wb_if_pending", 64'(ramREN), 64'h0);
        step(); ramstate = ACCESS; ramload = 32'h3333; #1;
        chk("wbif_addr", 64'(ramaddr), 64'h300);
        chk("wbif_iload", 64'(iload), {32'h0, 32'h3333});
        chk("wbif_iwait", 64'(iwait), 64'h2);
        step(); iREN = 2'b00; ramstate = FREE;

        // CPU0 BusRdX, CPU1 holds the line modified: cache-to-cache
        step(); dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h40; #1;
        chk("c2c_idle_ccwait", 64'(ccwait), 64'h0);
        step(); #1;
        chk("c2c_snp_ccwait", 64'(ccwait), 64'h2);
        chk("c2c_snp_ccinv", 64'(ccinv), 64'h2);
        chk("c2c_snp_addr", 64'(ccsnoopaddr), {32'h40, 32'h0});
        chk("c2c_snp_dwait", 64'(dwait), 64'h3);
        step(); dWEN = 2'b10; daddr[1] = 32'h40; dstore[1] = 32'hBEEF; #1;
        chk("c2c_resp_ccwait", 64'(ccwait), 64'h2);
        chk("c2c_resp_wen", 64'(ramWEN), 64'h0);
        step(); ramstate = ACCESS; #1;
        chk("c2c_ram", 64'({ramREN, ramWEN}), 64'h1);
        chk("c2c_addr", 64'(ramaddr), 64'h40);
        chk("c2c_store", 64'(ramstore), 64'hBEEF);
        chk("c2c_dload", 64'(dload), {32'h0, 32'hBEEF});
        chk("c2c_dwait", 64'(dwait), 64'h0);
        step(); dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = FREE; #1;
        chk("c2c_end_ccwait", 64'(ccwait), 64'h0);
        chk("c2c_end_ram", 64'({ramREN, ramWEN}), 64'h0);
        step();

        // CPU0 upgrade S->M: single snoop cycle, no RAM traffic
        step(); cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h60; #1;
        chk("upg_idle_dwait", 64'(dwait), 64'h3);
        step(); #1;
        chk("upg_ccinv", 64'(ccinv), 64'h2);
        chk("upg_addr", 64'(ccsnoopaddr), {32'h60, 32'h0});
        chk("upg_dwait", 64'(dwait), 64'h2);
        chk("upg_ram", 64'({ramREN, ramWEN}), 64'h0);
        step(); cctrans = '0; ccwrite = '0; #1;
        chk("upg_end_ccinv", 64'(ccinv), 64'h0);
        chk("upg_end_dwait", 64'(dwait), 64'h3);

        // reset while a RAM load is in flight
        step(); dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h90; #1;
        step(); #1;
        chk("ld_snp_ccinv", 64'(ccinv), 64'h0);
        step(); #1;
        step(); ramstate = BUSY; #1;
        chk("ld_ren", 64'(ramREN), 64'h1);
        chk("ld_addr", 64'(ramaddr), 64'h90);
        nRST = 1'b0; #1;
        chk("ld_rst_ren", 64'(ramREN), 64'h0);
        chk("ld_rst_waits", 64'({iwait, dwait}), 64'hF);
        chk("ld_rst_ccwait", 64'(ccwait), 64'h0);
        dREN = '0; cctrans = '0; ramstate = FREE;
        step(); nRST = 1'b1;
        step(); iREN = 2'b11; iaddr[0] = 32'h500; iaddr[1] = 32'h600; #1;
        chk("post_rst_idle", 64'({ramREN, ramWEN, ccwait}), 64'h0);
        step(); ramstate = ACCESS; ramload = 32'h5555; #1;
        chk("post_rst_rr_addr", 64'(ramaddr), 64'h500);
        chk("post_rst_iwait", 64'(iwait), 64'h2);
        step(); iREN = '0; ramstate = FREE;

        // two-word writeback stays on CPU0
        step(); dWEN = 2'b01; daddr[0] = 32'hA0; dstore[0] = 32'h1; #1;
        step(); ramstate = ACCESS; #1;
        chk("wb2_w0_dwait", 64'(dwait), 64'h2);
        chk("wb2_w0_addr", 64'(ramaddr), 64'hA0);
        step(); daddr[0] = 32'hA4; dstore[0] = 32'h2; ramstate = BUSY; #1;
        chk("wb2_w1_wen", 64'(ramWEN), 64'h1);
        chk("wb2_w1_addr", 64'(ramaddr), 64'hA4);
        chk("wb2_w1_busy", 64'(dwait), 64'h3);
        step(); ramstate = ACCESS; #1;
        chk("wb2_w1_dwait", 64'(dwait), 64'h2);
        chk("wb2_w1_store", 64'(ramstore), 64'h2);
        step(); dWEN = '0; ramstate = FREE; #1;
        chk("wb2_end_wen", 64'(ramWEN), 64'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/coherence_control.md
Name: coherence_control

Overview:
Bus controller on the controller side of the cache/coherence interface, between two CPUs' icache/dcache pairs and the single RAM. It arbitrates instruction fetches, dcache writebacks and coherent dcache misses onto one RAM port. It implements MSI snooping: it broadcasts the snoop address, invalidates the other cache and performs cache-to-cache transfers.

Parameters:
CPUS, 2, number of CPUs. Only 2 is supported; the other-cache index is the inverse of the requester index.

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
iREN  input  CPUS  icache read request
dREN  input  CPUS  dcache read request
dWEN  input  CPUS  dcache write request
iaddr  input  CPUS x 32  icache word address
daddr  input  CPUS x 32  dcache word address
dstore  input  CPUS x 32  dcache write data
ccwrite  input  CPUS  miss intends to modify (BusRdX or upgrade)
cctrans  input  CPUS  dcache request is a coherence state transition
ramload  input  32  RAM read data
ramstate  input  ramstate_t  FREE/BUSY/ACCESS/ERROR
iwait  output  CPUS  icache stall
dwait  output  CPUS  dcache stall
iload  output  CPUS x 32  icache read data
dload  output  CPUS x 32  dcache read data
ccwait  output  CPUS  snooped cache must block its CPU
ccinv  output  CPUS  snooped cache must invalidate the line
ccsnoopaddr  output  CPUS x 32  snoop address
ramstore  output  32  RAM write data
ramaddr  output  32  RAM address
ramWEN  output  1  RAM write enable
ramREN  output  1  RAM read enable

Behaviour:
- Reset (async, nRST=0): state IDLE; iwait=dwait='1; ccwait=ccinv='0; ccsnoopaddr, iload, dload, ramaddr, ramstore = 0; ramREN=ramWEN=0; rr_last=1, so CPU0 wins first. ramREN/ramWEN drop immediately on reset mid-transaction.
- Registered: state, granted CPU (gnt), rr_last. All cache and RAM outputs are combinational from state, gnt and inputs.
- ramREN and ramWEN are never high together. RAM latency is variable. BUSY and ERROR both mean keep holding the request.
- A wait line drops for exactly the single cycle in which ramstate==ACCESS (or the snoop completes) for the granted transaction. It is high at all other times.
- Arbitration happens in IDLE only. Class priority: writeback (dWEN & ~cctrans), then coherent miss/upgrade (cctrans), then ifetch. Within a class, two requesting CPUs are round-robin (the CPU other than rr_last wins). rr_last updates on each completed transaction. IDLE to grant costs 1 cycle.
- WB: ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[gnt]. On ACCESS, dwait[gnt]=0. If dWEN[gnt] is still high in the next cycle (second block word), stay in WB for the same CPU; otherwise go to IDLE.
- SNOOP (1 cycle, o = ~gnt): ccwait[o]=1, ccsnoopaddr[o]=daddr[gnt], ccinv[o]=ccwrite[gnt].
  - Upgrade (ccwrite & ~dREN & ~dWEN): dwait[gnt]=0 in this cycle, then IDLE.
  - Otherwise go to SRESP.
- SRESP: ccwait[o] and ccsnoopaddr[o] stay held. If dWEN[o]=1 (o holds the line in M), go to C2C; else go to RAMLD.
- C2C: ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[gnt]=dstore[o]. On ACCESS, dwait[o]=0 and dwait[gnt]=0 in the same cycle.
- RAMLD: ramREN=1, ramaddr=daddr[gnt]. On ACCESS, dload[gnt]=ramload and dwait[gnt]=0.
- After C2C or RAMLD completes: if dREN[gnt]&cctrans[gnt] is still high next cycle (second block word), return to SNOOP without re-arbitrating. Otherwise go to IDLE and drop ccwait[o].
- IFETCH: ramREN=1, ramaddr=iaddr[gnt]. On ACCESS, iload[gnt]=ramload and iwait[gnt]=0; then IDLE.
- Same CPU with both icache and dcache pending: the dcache is served first; the icache waits.
- A request withdrawn before ACCESS (requester drops its enable): the controller completes the RAM handshake anyway and ignores the result.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (existing); add cc_state_t {IDLE, WB, SNOOP, SRESP, C2C, RAMLD, IFETCH}.
- One sub-module, cc_rr_arbiter: 2-way round-robin with priority classes; outputs gnt and class; rr_last is held inside it.

Test Plan:
- Reset with ramstate=FREE, no requests -> iwait=dwait=2'b11, ramREN=ramWEN=0, ccwait=0.
- iREN=2'b11, iaddr0=0x100, iaddr1=0x200, RAM ACCESS after 2 cycles -> CPU0 served first (iload[0]=ramload, iwait[0] low 1 cycle), then CPU1 at 0x200.
- CPU1 dWEN (no cctrans) at 0x80 with data 0xDEAD, concurrent with CPU0 iREN -> ramWEN, ramstore=0xDEAD, dwait[1] low 1 cycle; the ifetch starts only afterwards.
- CPU0 dREN+cctrans+ccwrite at 0x40, CPU1 responds dWEN with dstore=0xBEEF -> ccinv[1]=1 and ccsnoopaddr[1]=0x40; dload[0]=0xBEEF; RAM written with 0xBEEF; dwait[0] and dwait[1] low in the same cycle.
- CPU0 upgrade (cctrans, ccwrite, no dREN/dWEN) at 0x60 -> ccinv[1]=1 for one cycle, dwait[0] low that cycle, no RAM access.
- nRST asserted during RAMLD with ramREN high -> ramREN=0 immediately, all waits high, state IDLE after release.
